// File: rtl/sdio_response_source.sv
// Byte source for the sdio_slave response interface: count-down pattern,
// incrementing pattern, or bytes from an internal FIFO. All outputs are registered.
module sdio_response_source #(
  parameter int          COUNT_WIDTH    = 9,
  parameter int          FIFO_DEPTH     = 512,
  parameter logic [7:0]  PATTERN_OFFSET = 8'h35,
  localparam int         AW             = $clog2(FIFO_DEPTH),
  localparam int         LW             = AW + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] start_count,
  input  logic [7:0]             seed,
  input  logic                   fifo_write_strobe,
  input  logic [7:0]             fifo_write_data,
  input  logic                   fifo_flush,
  output logic                   fifo_full,
  output logic [LW-1:0]          fifo_level,
  output logic                   response_start_write,
  input  logic                   response_data_req,
  output logic [7:0]             response_data,
  output logic                   response_data_strobe,
  output logic                   response_data_empty,
  output logic                   busy,
  output logic                   underrun,
  output logic                   overflow
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [7:0]             index_q, index_d;
  logic [7:0]             data_q, data_d;
  logic                   strobe_q, strobe_d;
  logic                   start_write_q, start_write_d;
  logic                   empty_q, empty_d;
  logic                   busy_q, busy_d;
  logic                   underrun_q, underrun_d;
  logic                   overflow_q, overflow_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [7:0]             mem_q [FIFO_DEPTH];

  logic                      pop, push, flush_ok, full;
  logic [COUNT_WIDTH+7:0]    rem_ext;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign rem_ext = {8'h00, remaining_q};

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    remaining_d   = remaining_q;
    index_d       = index_q;
    data_d        = data_q;
    strobe_d      = 1'b0;
    start_write_d = 1'b0;
    empty_d       = empty_q;
    busy_d        = busy_q;
    underrun_d    = underrun_q;
    pop           = 1'b0;

    // A start with a non-zero mode wins over any request, so it also aborts STREAM.
    if (start && (mode != 2'd0)) begin
      mode_d        = mode;
      remaining_d   = start_count;
      index_d       = seed;
      start_write_d = 1'b1;
      empty_d       = 1'b0;
      busy_d        = 1'b1;
      state_d       = STREAM;
    end else if ((state_q == STREAM) && response_data_req) begin
      if (remaining_q != '0) begin
        remaining_d = remaining_q - COUNT_WIDTH'(1);
        strobe_d    = 1'b1;
        case (mode_q)
          2'd1: data_d = rem_ext[7:0] + PATTERN_OFFSET;
          2'd3: begin
            data_d  = index_q;
            index_d = index_q + 8'd1;
          end
          2'd2: begin
            // Only bytes present before this cycle are poppable.
            if (level_q != '0) begin
              data_d = mem_q[rd_ptr_q];
              pop    = 1'b1;
            end else begin
              data_d     = 8'h00;
              underrun_d = 1'b1;
            end
          end
          default: data_d = data_q;
        endcase
      end else begin
        empty_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    flush_ok   = fifo_flush && !busy_q;
    push       = fifo_write_strobe && (!full || pop) && !flush_ok;
    overflow_d = overflow_q | (fifo_write_strobe && full && !pop && !flush_ok);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (flush_ok) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mode_q        <= 2'd0;
      remaining_q   <= '0;
      index_q       <= 8'h00;
      data_q        <= 8'h00;
      strobe_q      <= 1'b0;
      start_write_q <= 1'b0;
      empty_q       <= 1'b0;
      busy_q        <= 1'b0;
      underrun_q    <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      remaining_q   <= remaining_d;
      index_q       <= index_d;
      data_q        <= data_d;
      strobe_q      <= strobe_d;
      start_write_q <= start_write_d;
      empty_q       <= empty_d;
      busy_q        <= busy_d;
      underrun_q    <= underrun_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clock) begin
    if (!reset && push) mem_q[wr_ptr_q] <= fifo_write_data;
  end

  assign fifo_full            = full;
  assign fifo_level           = level_q;
  assign response_start_write = start_write_q;
  assign response_data        = data_q;
  assign response_data_strobe = strobe_q;
  assign response_data_empty  = empty_q;
  assign busy                 = busy_q;
  assign underrun             = underrun_q;
  assign overflow             = overflow_q;

endmodule

// File: tb/tb_sdio_response_source.sv
// Self-checking bench for sdio_response_source: table-driven pattern transfers
// plus hand-written FIFO, restart and reset sequences, with a byte scoreboard.
module tb_sdio_response_source;
  localparam int CW = 9;
  localparam int D  = 16;
  localparam int LW = $clog2(D) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          start = 1'b0;
  logic [CW-1:0] start_count = '0;
  logic [7:0]    seed = 8'h00;
  logic          fifo_write_strobe = 1'b0;
  logic [7:0]    fifo_write_data = 8'h00;
  logic          fifo_flush = 1'b0;
  logic          fifo_full;
  logic [LW-1:0] fifo_level;
  logic          response_start_write;
  logic          response_data_req = 1'b0;
  logic [7:0]    response_data;
  logic          response_data_strobe;
  logic          response_data_empty;
  logic          busy;
  logic          underrun;
  logic          overflow;

  sdio_response_source #(.COUNT_WIDTH(CW), .FIFO_DEPTH(D), .PATTERN_OFFSET(8'h35)) dut (
    .clock(clock), .reset(reset), .mode(mode), .start(start), .start_count(start_count),
    .seed(seed), .fifo_write_strobe(fifo_write_strobe), .fifo_write_data(fifo_write_data),
    .fifo_flush(fifo_flush), .fifo_full(fifo_full), .fifo_level(fifo_level),
    .response_start_write(response_start_write), .response_data_req(response_data_req),
    .response_data(response_data), .response_data_strobe(response_data_strobe),
    .response_data_empty(response_data_empty), .busy(busy), .underrun(underrun),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q [$];
  logic [7:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Every strobed byte must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (response_data_strobe === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe got %0h want no strobe", response_data);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("strobe_data", {24'h0, response_data}, {24'h0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [CW-1:0] c, input logic [7:0] s);
    mode = m; start_count = c; seed = s; start = 1'b1;
    tick();
    start = 1'b0;
    if (m != 2'd0) begin
      chk("start_write_pulse", response_start_write, 1);
      chk("start_busy", busy, 1);
      chk("start_empty_clear", response_data_empty, 0);
    end else begin
      chk("mode0_no_start_write", response_start_write, 0);
      chk("mode0_not_busy", busy, 0);
    end
    tick();
    chk("start_write_one_cycle", response_start_write, 0);
  endtask

  task automatic req_byte(input logic [7:0] exp, input logic wr, input logic [7:0] wd);
    response_data_req = 1'b1;
    fifo_write_strobe = wr;
    fifo_write_data   = wd;
    sb_q.push_back(exp);
    tick();
    response_data_req = 1'b0;
    fifo_write_strobe = 1'b0;
    chk("strobe_latency", response_data_strobe, 1);
  endtask

  task automatic req_end();
    response_data_req = 1'b1;
    tick();
    response_data_req = 1'b0;
    chk("end_no_strobe", response_data_strobe, 0);
    chk("end_empty", response_data_empty, 1);
    chk("end_busy", busy, 0);
  endtask

  task automatic fifo_push(input logic [7:0] d);
    fifo_write_strobe = 1'b1;
    fifo_write_data   = d;
    tick();
    fifo_write_strobe = 1'b0;
  endtask

  task automatic chk_all_zero();
    chk("rst_start_write", response_start_write, 0);
    chk("rst_data", {24'h0, response_data}, 0);
    chk("rst_strobe", response_data_strobe, 0);
    chk("rst_empty", response_data_empty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", {27'h0, fifo_level}, 0);
    chk("rst_full", fifo_full, 0);
  endtask

  typedef struct {
    logic [1:0]      mode;
    logic [CW-1:0]   cnt;
    logic [7:0]      seed;
    int              n;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{mode: 2'd1, cnt: 9'd3, seed: 8'h00, n: 3, exp: {8'h00, 8'h36, 8'h37, 8'h38}};
    vecs[1] = '{mode: 2'd3, cnt: 9'd3, seed: 8'hFE, n: 3, exp: {8'h00, 8'h00, 8'hFF, 8'hFE}};
    vecs[2] = '{mode: 2'd1, cnt: 9'd0, seed: 8'h00, n: 0, exp: 32'h0};
    vecs[3] = '{mode: 2'd3, cnt: 9'd2, seed: 8'h10, n: 2, exp: {8'h00, 8'h00, 8'h11, 8'h10}};
    vecs[4] = '{mode: 2'd1, cnt: 9'd4, seed: 8'h00, n: 4, exp: {8'h36, 8'h37, 8'h38, 8'h39}};

    repeat (3) @(posedge clock);
    #1;
    chk_all_zero();
    reset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].mode, vecs[v].cnt, vecs[v].seed);
      for (int i = 0; i < vecs[v].n; i++) req_byte(vecs[v].exp[i], 1'b0, 8'h00);
      req_end();
    end

    // Idle request: no strobe, empty stays as left.
    response_data_req = 1'b1;
    tick();
    response_data_req = 1'b0;
    chk("idle_req_no_strobe", response_data_strobe, 0);
    chk("idle_req_empty_held", response_data_empty, 1);

    // FIFO mode with underrun on the third byte.
    chk("underrun_initially_clear", underrun, 0);
    fifo_push(8'hA1);
    fifo_push(8'hB2);
    chk("fifo_level_2", {27'h0, fifo_level}, 2);
    do_start(2'd2, 9'd3, 8'h00);
    req_byte(8'hA1, 1'b0, 8'h00);
    req_byte(8'hB2, 1'b0, 8'h00);
    req_byte(8'h00, 1'b0, 8'h00);
    chk("underrun_set", underrun, 1);
    chk("fifo_level_0", {27'h0, fifo_level}, 0);
    req_end();

    // Flush, and flush beating a simultaneous write.
    fifo_push(8'h11);
    fifo_push(8'h22);
    fifo_flush = 1'b1;
    tick();
    fifo_flush = 1'b0;
    chk("flush_level", {27'h0, fifo_level}, 0);
    fifo_flush = 1'b1;
    fifo_write_strobe = 1'b1;
    fifo_write_data = 8'h33;
    tick();
    fifo_flush = 1'b0;
    fifo_write_strobe = 1'b0;
    chk("flush_wins_level", {27'h0, fifo_level}, 0);

    // Fill to full, then one extra write.
    for (int i = 0; i < D; i++) fifo_push(8'h40 + 8'(i));
    chk("full_set", fifo_full, 1);
    chk("no_overflow_at_depth", overflow, 0);
    fifo_push(8'h40 + 8'(D));
    chk("overflow_set", overflow, 1);
    chk("level_at_depth", {27'h0, fifo_level}, D);

    // Push and pop together while full: level holds, new byte comes out last.
    do_start(2'd2, 9'(D + 1), 8'h00);
    req_byte(8'h40, 1'b1, 8'hEE);
    chk("push_pop_full_level", {27'h0, fifo_level}, D);
    chk("push_pop_full_full", fifo_full, 1);
    for (int i = 1; i < D; i++) req_byte(8'h40 + 8'(i), 1'b0, 8'h00);
    req_byte(8'hEE, 1'b0, 8'h00);
    chk("drained_level", {27'h0, fifo_level}, 0);
    req_end();

    // Restart mid-transfer.
    do_start(2'd1, 9'd5, 8'h00);
    req_byte(8'h3A, 1'b0, 8'h00);
    req_byte(8'h39, 1'b0, 8'h00);
    do_start(2'd1, 9'd2, 8'h00);
    req_byte(8'h37, 1'b0, 8'h00);
    req_byte(8'h36, 1'b0, 8'h00);
    req_end();

    // Reset in the middle of a stream.
    do_start(2'd3, 9'd4, 8'h05);
    req_byte(8'h05, 1'b0, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero();
    response_data_req = 1'b1;
    tick();
    response_data_req = 1'b0;
    chk("post_reset_no_strobe", response_data_strobe, 0);
    chk("post_reset_not_busy", busy, 0);
    do_start(2'd0, 9'd3, 8'h00);

    repeat (2) tick();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
